// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - load/store initiator between the MEM stage and a word-only data memory
// Sub-word stores use read-modify-write; misaligned requests are flagged or force-aligned.
module lsu_rmw #(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t state;
    state_t state_next;

    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic              err_q;

    logic [1:0]        in_size;
    logic              in_mis;
    logic              in_err;
    logic [ADDR_W-1:0] in_addr;
    logic              accept;

    logic [4:0]        lane_sh;
    logic [31:0]       lane_mask;
    logic [31:0]       merged;
    logic [31:0]       shifted;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] word_addr;

    // Size 11 behaves as word; without alignment checking the low bits are dropped.
    always_comb begin
        in_size = (req_size == 2'b11) ? SZ_W : req_size;
        in_mis  = ((in_size == SZ_H) && req_addr[0]) ||
                  ((in_size == SZ_W) && (req_addr[1:0] != 2'b00));
        in_err  = in_mis && CHECK_ALIGN;
        in_addr = req_addr;
        if (!CHECK_ALIGN) begin
            if (in_size == SZ_H) begin
                in_addr[0] = 1'b0;
            end else if (in_size == SZ_W) begin
                in_addr[1:0] = 2'b00;
            end
        end
    end

    assign accept = req_valid && (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            size_q  <= in_size;
            sign_q  <= req_sign;
            addr_q  <= in_addr;
            wdata_q <= req_wdata;
            err_q   <= in_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
        end else if (state == RD) begin
            word_q <= mem_rd;
        end
    end

    // Lane selection: a word request is always aligned, so its shift is zero and
    // the full mask makes the merge collapse to wdata_q.
    always_comb begin
        lane_sh = (size_q == SZ_H) ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_B:    lane_mask = 32'h0000_00FF;
            SZ_H:    lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        merged  = (word_q & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
        shifted = word_q >> lane_sh;
        case (size_q)
            SZ_B:    load_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (in_err) begin
                        state_next = RESP;
                    end else if (req_we && (in_size == SZ_W)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                mem_addr   = word_addr;
                state_next = we_q ? WR : RESP;
            end
            WR: begin
                mem_addr   = word_addr;
                mem_we     = 1'b1;
                mem_wd     = merged;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 32'h0 : load_data;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - self-checking bench for lsu_rmw, aligned-check and force-aligned variants
// Instance "a" has CHECK_ALIGN=1, instance "n" has CHECK_ALIGN=0; both share request inputs.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_we;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wd, a_mem_rd;
    logic        n_req_ready, n_resp_valid, n_resp_err, n_mem_we;
    logic [31:0] n_resp_rdata, n_mem_addr, n_mem_wd, n_mem_rd;

    logic [31:0] mem_a [256];
    logic [31:0] mem_n [256];
    logic [31:0] refm [2][256];
    logic        preloaded;

    int    checks = 0;
    int    errors = 0;
    string tag;

    always #5 clk = ~clk;

    lsu_rmw #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wd(a_mem_wd), .mem_rd(a_mem_rd)
    );

    lsu_rmw #(.ADDR_W(32), .CHECK_ALIGN(1'b0)) dut_n (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(n_req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
        .mem_addr(n_mem_addr), .mem_we(n_mem_we), .mem_wd(n_mem_wd), .mem_rd(n_mem_rd)
    );

    function automatic logic [31:0] seed(input int i);
        logic [31:0] x;
        x = i;
        if (i == 64) return 32'h8899_AABB;
        return (x * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    assign a_mem_rd = mem_a[a_mem_addr[9:2]];
    assign n_mem_rd = mem_n[n_mem_addr[9:2]];

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= seed(i);
                mem_n[i] <= seed(i);
            end
        end else begin
            if (a_mem_we) mem_a[a_mem_addr[9:2]] <= a_mem_wd;
            if (n_mem_we) mem_n[n_mem_addr[9:2]] <= n_mem_wd;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, name, got, exp);
        end
    endtask

    // Reference model: byte-array view of the addressed word, little-endian lanes.
    task automatic model(input int k, input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic wr, output logic [31:0] waddr, output logic [31:0] wword);
        int          n;
        int          base;
        logic [31:0] a;
        logic [31:0] w;
        logic [7:0]  b [4];
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a = addr;
        rdata = 0; err = 0; lat = 0; wr = 0; waddr = 0; wword = 0;
        if ((addr % n) != 0) begin
            if (k == 1) begin
                err = 1;
                lat = 1;
                return;
            end
            a = addr - (addr % n);
        end
        base = a % 4;
        w = refm[k][a[9:2]];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        if (!we) begin
            for (int i = 0; i < n; i++) rdata[8*i +: 8] = b[base + i];
            if (sign && n < 4 && b[base + n - 1][7])
                for (int i = n; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
            lat = 2;
        end else begin
            for (int i = 0; i < n; i++) b[base + i] = wdata[8*i +: 8];
            for (int i = 0; i < 4; i++) w[8*i +: 8] = b[i];
            refm[k][a[9:2]] = w;
            wr    = 1;
            waddr = {a[31:2], 2'b00};
            wword = w;
            lat   = (n == 4) ? 2 : 3;
        end
    endtask

    // Starts at a negedge with both units idle; ends at a negedge with both idle again.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit use_tab, input logic [31:0] t_rdata, input logic t_err,
                           input int t_lat, input logic [31:0] t_wd, input logic [31:0] t_na);
        logic [31:0] e_rd [2], e_wa [2], e_ww [2];
        logic        e_err [2], e_wr [2];
        int          e_lat [2];
        logic [31:0] g_rd [2], g_wa [2], g_ww [2];
        logic        g_err [2], g_rdy1 [2];
        int          g_lat [2], g_cnt [2], g_wecnt [2], g_wecyc [2];
        logic [1:0]  s_rv, s_err, s_rdy, s_we;
        logic [31:0] s_rd [2], s_ma [2], s_wd [2];
        string       pfx;
        for (int k = 0; k < 2; k++) begin
            model(k, we, size, sign, addr, wdata, e_rd[k], e_err[k], e_lat[k], e_wr[k], e_wa[k], e_ww[k]);
            g_rd[k] = 0; g_wa[k] = 0; g_ww[k] = 0; g_err[k] = 0; g_rdy1[k] = 1;
            g_lat[k] = 0; g_cnt[k] = 0; g_wecnt[k] = 0; g_wecyc[k] = 0;
        end
        if (use_tab) begin
            e_rd[1]  = t_rdata;
            e_err[1] = t_err;
            e_lat[1] = t_lat;
            if (e_wr[1]) e_ww[1] = t_wd;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            s_rv  = {a_resp_valid, n_resp_valid};
            s_err = {a_resp_err, n_resp_err};
            s_rdy = {a_req_ready, n_req_ready};
            s_we  = {a_mem_we, n_mem_we};
            s_rd[1] = a_resp_rdata; s_rd[0] = n_resp_rdata;
            s_ma[1] = a_mem_addr;   s_ma[0] = n_mem_addr;
            s_wd[1] = a_mem_wd;     s_wd[0] = n_mem_wd;
            for (int k = 0; k < 2; k++) begin
                if (c == 1) g_rdy1[k] = s_rdy[k];
                if (s_rv[k]) begin
                    g_cnt[k]++;
                    if (g_lat[k] == 0) begin
                        g_lat[k] = c; g_rd[k] = s_rd[k]; g_err[k] = s_err[k];
                    end
                end
                if (s_we[k]) begin
                    g_wecnt[k]++; g_wecyc[k] = c; g_wa[k] = s_ma[k]; g_ww[k] = s_wd[k];
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            pfx = (k == 1) ? "a" : "n";
            chk({pfx, " latency"}, g_lat[k], e_lat[k]);
            chk({pfx, " rdata"}, g_rd[k], e_rd[k]);
            chk({pfx, " err"}, {31'b0, g_err[k]}, {31'b0, e_err[k]});
            chk({pfx, " resp pulses"}, g_cnt[k], 1);
            chk({pfx, " busy ready"}, {31'b0, g_rdy1[k]}, 0);
            chk({pfx, " we cycles"}, g_wecnt[k], e_wr[k] ? 1 : 0);
            if (e_wr[k]) begin
                chk({pfx, " we cycle"}, g_wecyc[k], e_lat[k] - 1);
                chk({pfx, " mem_addr"}, g_wa[k], e_wa[k]);
                chk({pfx, " mem_wd"}, g_ww[k], e_ww[k]);
            end
        end
        if (use_tab && t_err) chk("n forced-align rdata", g_rd[0], t_na);
    endtask

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
        logic [31:0] wd;
        logic [31:0] na;
    } vec_t;

    vec_t vecs [14];

    initial begin
        reset = 1'b0; preloaded = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_size = 2'b00; req_sign = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 256; i++) begin
            refm[0][i] = seed(i);
            refm[1][i] = seed(i);
        end
        //         we    size   sign  addr          wdata         rdata         err  lat   wd            forced-align rdata
        vecs[0]  = {1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        32'hFFFFFFAA, 1'b0, 4'd2, 32'h0,        32'h0};
        vecs[1]  = {1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        32'h000000AA, 1'b0, 4'd2, 32'h0,        32'h0};
        vecs[2]  = {1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        32'hFFFF8899, 1'b0, 4'd2, 32'h0,        32'h0};
        vecs[3]  = {1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h8899AABB, 1'b0, 4'd2, 32'h0,        32'h0};
        vecs[4]  = {1'b1, 2'd0, 1'b0, 32'h103, 32'h12345677, 32'h0,        1'b0, 4'd3, 32'h7799AABB, 32'h0};
        vecs[5]  = {1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h7799AABB, 1'b0, 4'd2, 32'h0,        32'h0};
        vecs[6]  = {1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 4'd2, 32'hDEADBEEF, 32'h0};
        vecs[7]  = {1'b0, 2'd2, 1'b0, 32'h104, 32'h0,        32'hDEADBEEF, 1'b0, 4'd2, 32'h0,        32'h0};
        vecs[8]  = {1'b0, 2'd1, 1'b1, 32'h101, 32'h0,        32'h0,        1'b1, 4'd1, 32'h0,        32'hFFFFAABB};
        vecs[9]  = {1'b1, 2'd1, 1'b0, 32'h106, 32'h0000CAFE, 32'h0,        1'b0, 4'd3, 32'hCAFEBEEF, 32'h0};
        vecs[10] = {1'b0, 2'd1, 1'b0, 32'h106, 32'h0,        32'h0000CAFE, 1'b0, 4'd2, 32'h0,        32'h0};
        vecs[11] = {1'b0, 2'd0, 1'b1, 32'h107, 32'h0,        32'hFFFFFFCA, 1'b0, 4'd2, 32'h0,        32'h0};
        vecs[12] = {1'b1, 2'd2, 1'b0, 32'h102, 32'h01020304, 32'h0,        1'b1, 4'd1, 32'h0,        32'h0};
        vecs[13] = {1'b0, 2'd3, 1'b0, 32'h104, 32'h0,        32'hCAFEBEEF, 1'b0, 4'd2, 32'h0,        32'h0};

        @(negedge clk);
        preloaded = 1'b1;
        tag = "reset";
        chk("a req_ready", {31'b0, a_req_ready}, 1);
        chk("a resp_valid", {31'b0, a_resp_valid}, 0);
        chk("a resp_rdata", a_resp_rdata, 0);
        chk("a resp_err", {31'b0, a_resp_err}, 0);
        chk("a mem_addr", a_mem_addr, 0);
        chk("a mem_we", {31'b0, a_mem_we}, 0);
        chk("a mem_wd", a_mem_wd, 0);
        chk("n req_ready", {31'b0, n_req_ready}, 1);
        chk("n mem_we", {31'b0, n_mem_we}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            tag = $sformatf("vec%0d", i);
            run_req(vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata,
                    1'b1, vecs[i].rdata, vecs[i].err, int'(vecs[i].lat), vecs[i].wd, vecs[i].na);
        end

        // Reset while a halfword store sits in WR: the write must vanish with no response.
        tag = "reset-in-wr";
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_sign = 1'b0;
        req_addr = 32'h108; req_wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("a ready in RD", {31'b0, a_req_ready}, 0);
        chk("a mem_addr in RD", a_mem_addr, 32'h108);
        @(posedge clk);
        #2;
        chk("a mem_we in WR", {31'b0, a_mem_we}, 1);
        chk("n mem_we in WR", {31'b0, n_mem_we}, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("a mem_we after reset", {31'b0, a_mem_we}, 0);
        chk("n mem_we after reset", {31'b0, n_mem_we}, 0);
        chk("a resp_valid after reset", {31'b0, a_resp_valid}, 0);
        chk("a ready after reset", {31'b0, a_req_ready}, 1);
        repeat (2) begin
            @(negedge clk);
            chk("a resp_valid held in reset", {31'b0, a_resp_valid}, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("a ready after release", {31'b0, a_req_ready}, 1);
        chk("a resp_valid after release", {31'b0, a_resp_valid}, 0);
        tag = "post-reset load";
        run_req(1'b0, 2'd2, 1'b0, 32'h108, 32'h0, 1'b0, 32'h0, 1'b0, 0, 32'h0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            tag = $sformatf("rand%0d", i);
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 1023)), $urandom, 1'b0, 32'h0, 1'b0, 0, 32'h0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
